// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, IF/ID entry layout and fetch constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetchState_t;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifIdEntry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline latch: hold beats flush, flush beats the fetched word.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcPlus4In,
    output ifIdEntry_t  entry
);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            entry <= '{instr: NOP_WORD, pcPlus4: 32'h0, valid: 1'b0};
        end else if (load) begin
            if (flush)
                entry <= '{instr: NOP_WORD, pcPlus4: pcPlus4In, valid: 1'b0};
            else
                entry <= '{instr: instrIn, pcPlus4: pcPlus4In, valid: 1'b1};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, redirect/stall handling, fetch FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating StallCycles / FlushCycles counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PCWrite,
    input  logic        DecodeRegWrite,
    input  logic        flushControl,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] InstrAddr,
    input  logic [31:0] InstrData,
    output logic [31:0] DecodeInstruction,
    output logic [31:0] DecodePCPlus4,
    output logic        DecodeValid,
    output logic [1:0]  FetchState
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
`endif
);

    logic [31:0] pc, pcPlus4, pcNext;
    logic        redirect;
    fetchState_t state, stateNext;
    ifIdEntry_t  ifId;

    assign pcPlus4  = pc + PC_INC;
    assign redirect = JumpTaken | BranchTaken;

    // Redirects win over a stall: decode only asserts them for resolved branches.
    always_comb begin
        pcNext = pcPlus4;
        if (JumpTaken)
            pcNext = alignWord(JumpTarget);
        else if (BranchTaken)
            pcNext = alignWord(BranchTarget);
        else if (!PCWrite)
            pcNext = pc;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) pc <= RESET_PC;
        else      pc <= pcNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            BOOT:    stateNext = RUN;
            RUN:     if (!PCWrite && !redirect) stateNext = STALL;
            STALL:   if (PCWrite || redirect)   stateNext = RUN;
            default: stateNext = BOOT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) state <= BOOT;
        else      state <= stateNext;
    end

    // The wrong-path word behind a redirect is squashed the same way as a flush.
    if_id_reg uIfId (
        .clk       (Clk),
        .rstN      (Rst),
        .load      (DecodeRegWrite),
        .flush     (flushControl | redirect),
        .instrIn   (InstrData),
        .pcPlus4In (pcPlus4),
        .entry     (ifId)
    );

    assign InstrAddr         = pc;
    assign DecodeInstruction = ifId.instr;
    assign DecodePCPlus4     = ifId.pcPlus4;
    assign DecodeValid       = ifId.valid;
    assign FetchState        = state;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            StallCycles <= 32'h0;
            FlushCycles <= 32'h0;
        end else begin
            if (state == STALL && StallCycles != 32'hFFFF_FFFF)
                StallCycles <= StallCycles + 32'd1;
            if (DecodeRegWrite && (flushControl || redirect) && FlushCycles != 32'hFFFF_FFFF)
                FlushCycles <= FlushCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan scenarios plus a randomized run
// against a cycle-level reference model. Memory word at byte address 4*i is 32'h1000_0000+i.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst, PCWrite, DecodeRegWrite, flushControl;
    logic        BranchTaken, JumpTaken;
    logic [31:0] BranchTarget, JumpTarget;
    logic [31:0] InstrAddr, InstrData, DecodeInstruction, DecodePCPlus4;
    logic        DecodeValid;
    logic [1:0]  FetchState;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCycles;
`endif

    int nVec = 0;
    int nErr = 0;

    // Reference model state
    logic [31:0] mPc = 32'h0, mInstr = 32'h0, mPc4 = 32'h0;
    logic        mValid = 1'b0;
    int          mState = 0;
    longint      mStall = 0, mFlush = 0;

    always #5 Clk = ~Clk;

    assign InstrData = 32'h1000_0000 + {2'b00, InstrAddr[31:2]};

    fetch_stage dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .PCWrite           (PCWrite),
        .DecodeRegWrite    (DecodeRegWrite),
        .flushControl      (flushControl),
        .BranchTaken       (BranchTaken),
        .BranchTarget      (BranchTarget),
        .JumpTaken         (JumpTaken),
        .JumpTarget        (JumpTarget),
        .InstrAddr         (InstrAddr),
        .InstrData         (InstrData),
        .DecodeInstruction (DecodeInstruction),
        .DecodePCPlus4     (DecodePCPlus4),
        .DecodeValid       (DecodeValid),
        .FetchState        (FetchState)
`ifdef FETCH_PERF_CNT_EN
        ,
        .StallCycles       (StallCycles),
        .FlushCycles       (FlushCycles)
`endif
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // One clock edge of the intended behaviour, using the inputs held across the edge.
    task automatic modelEdge();
        logic [31:0] seq;
        bit redir;
        if (!Rst) begin
            mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
            mState = 0; mStall = 0; mFlush = 0;
        end else begin
            redir = JumpTaken || BranchTaken;
            seq   = mPc + 32'd4;
            if (DecodeRegWrite) begin
                mPc4 = seq;
                if (flushControl || redir) begin
                    mInstr = 32'h0; mValid = 1'b0;
                    if (mFlush < 64'hFFFF_FFFF) mFlush++;
                end else begin
                    mInstr = memWord(mPc); mValid = 1'b1;
                end
            end
            if (mState == 2 && mStall < 64'hFFFF_FFFF) mStall++;
            mState = (mState == 0 || redir || PCWrite) ? 1 : 2;
            if (JumpTaken)        mPc = JumpTarget & 32'hFFFF_FFFC;
            else if (BranchTaken) mPc = BranchTarget & 32'hFFFF_FFFC;
            else if (PCWrite)     mPc = seq;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        modelEdge();
        #1;
    endtask

    task automatic setIdle();
        PCWrite = 1'b1; DecodeRegWrite = 1'b1; flushControl = 1'b0;
        BranchTaken = 1'b0; JumpTaken = 1'b0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        setIdle();
        step();
        step();
        nVec++;
        if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState} !== {32'h0, 32'h0, 32'h0, 1'b0, 2'd0}) begin
            nErr++;
            $display("FAIL reset: addr=%h instr=%h pc4=%h vld=%b st=%0d, want 0/0/0/0/0",
                     InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState);
        end
`ifdef FETCH_PERF_CNT_EN
        nVec++;
        if (StallCycles !== 32'h0 || FlushCycles !== 32'h0) begin
            nErr++;
            $display("FAIL reset_counters: stall=%0d flush=%0d, want 0/0", StallCycles, FlushCycles);
        end
`endif
    endtask

    task automatic test_run();
        Rst = 1'b1;
        nVec++;
        if (DecodeValid !== 1'b0 || FetchState !== 2'd0) begin
            nErr++;
            $display("FAIL boot_cycle: vld=%b st=%0d, want 0/0", DecodeValid, FetchState);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            nVec++;
            if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState} !==
                {32'(4 * (i + 1)), 32'h1000_0000 + 32'(i), 32'(4 * (i + 1)), 1'b1, 2'd1}) begin
                nErr++;
                $display("FAIL run[%0d]: addr=%h instr=%h pc4=%h vld=%b st=%0d, want %h/%h/%h/1/1", i,
                         InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState,
                         4 * (i + 1), 32'h1000_0000 + i, 4 * (i + 1));
            end
        end
    endtask

    task automatic test_stall();
        PCWrite = 1'b0; DecodeRegWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            nVec++;
            if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState} !==
                {32'h10, 32'h1000_0003, 32'h10, 1'b1, 2'd2}) begin
                nErr++;
                $display("FAIL stall[%0d]: addr=%h instr=%h pc4=%h vld=%b st=%0d, want 10/10000003/10/1/2", i,
                         InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState);
            end
        end
        setIdle();
        step();
        nVec++;
        if ({InstrAddr, DecodeInstruction, DecodePCPlus4, FetchState} !== {32'h14, 32'h1000_0004, 32'h14, 2'd1}) begin
            nErr++;
            $display("FAIL stall_resume: addr=%h instr=%h pc4=%h st=%0d, want 14/10000004/14/1",
                     InstrAddr, DecodeInstruction, DecodePCPlus4, FetchState);
        end
`ifdef FETCH_PERF_CNT_EN
        nVec++;
        if (StallCycles !== 32'd3) begin
            nErr++;
            $display("FAIL stall_count: got %0d want 3", StallCycles);
        end
`endif
    endtask

    task automatic test_branch();
        step();
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        step();
        nVec++;
        if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid} !== {32'h40, 32'h0, 32'h1C, 1'b0}) begin
            nErr++;
            $display("FAIL branch_bubble: addr=%h instr=%h pc4=%h vld=%b, want 40/0/1c/0",
                     InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid);
        end
        setIdle();
        step();
        nVec++;
        if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid} !== {32'h44, 32'h1000_0010, 32'h44, 1'b1}) begin
            nErr++;
            $display("FAIL branch_target: addr=%h instr=%h pc4=%h vld=%b, want 44/10000010/44/1",
                     InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid);
        end
`ifdef FETCH_PERF_CNT_EN
        nVec++;
        if (FlushCycles !== 32'd1) begin
            nErr++;
            $display("FAIL flush_count: got %0d want 1", FlushCycles);
        end
`endif
    endtask

    task automatic test_jump_vs_branch();
        JumpTaken = 1'b1; JumpTarget = 32'h82;
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        step();
        nVec++;
        if (InstrAddr !== 32'h80 || DecodeValid !== 1'b0) begin
            nErr++;
            $display("FAIL jump_priority: addr=%h vld=%b, want 80/0", InstrAddr, DecodeValid);
        end
        setIdle();
    endtask

    task automatic test_wrap();
        JumpTaken = 1'b1; JumpTarget = 32'hFFFF_FFFC;
        step();
        nVec++;
        if (InstrAddr !== 32'hFFFF_FFFC) begin
            nErr++;
            $display("FAIL wrap_setup: addr=%h want fffffffc", InstrAddr);
        end
        setIdle();
        step();
        nVec++;
        if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid} !== {32'h0, 32'h4FFF_FFFF, 32'h0, 1'b1}) begin
            nErr++;
            $display("FAIL wrap: addr=%h instr=%h pc4=%h vld=%b, want 0/4fffffff/0/1",
                     InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid);
        end
    endtask

    task automatic test_reset_mid_stall();
        JumpTaken = 1'b1; JumpTarget = 32'h24;
        step();
        setIdle();
        PCWrite = 1'b0; DecodeRegWrite = 1'b0;
        step();
        nVec++;
        if (InstrAddr !== 32'h24 || FetchState !== 2'd2) begin
            nErr++;
            $display("FAIL pre_reset_stall: addr=%h st=%0d, want 24/2", InstrAddr, FetchState);
        end
        Rst = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h40;
        step();
        nVec++;
        if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState} !== {32'h0, 32'h0, 32'h0, 1'b0, 2'd0}) begin
            nErr++;
            $display("FAIL reset_mid_stall: addr=%h instr=%h pc4=%h vld=%b st=%0d, want 0/0/0/0/0",
                     InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState);
        end
`ifdef FETCH_PERF_CNT_EN
        nVec++;
        if (StallCycles !== 32'h0 || FlushCycles !== 32'h0) begin
            nErr++;
            $display("FAIL reset_mid_stall_counters: stall=%0d flush=%0d, want 0/0", StallCycles, FlushCycles);
        end
`endif
        Rst = 1'b1;
        setIdle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Rst            = ($urandom % 40) != 0;
            PCWrite        = ($urandom % 4) != 0;
            DecodeRegWrite = ($urandom % 4) != 0;
            flushControl   = ($urandom % 8) == 0;
            BranchTaken    = ($urandom % 8) == 0;
            JumpTaken      = ($urandom % 10) == 0;
            BranchTarget   = $urandom;
            JumpTarget     = $urandom;
            step();
            nVec++;
            if ({InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState} !==
                {mPc, mInstr, mPc4, mValid, 2'(mState)}) begin
                nErr++;
                $display("FAIL random[%0d]: addr=%h instr=%h pc4=%h vld=%b st=%0d, want %h/%h/%h/%b/%0d", i,
                         InstrAddr, DecodeInstruction, DecodePCPlus4, DecodeValid, FetchState,
                         mPc, mInstr, mPc4, mValid, mState);
            end
`ifdef FETCH_PERF_CNT_EN
            nVec++;
            if (StallCycles !== 32'(mStall) || FlushCycles !== 32'(mFlush)) begin
                nErr++;
                $display("FAIL random_counters[%0d]: stall=%0d flush=%0d, want %0d/%0d", i,
                         StallCycles, FlushCycles, mStall, mFlush);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_branch();
        test_jump_vs_branch();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
